lcd_spi_tx: RTL
===============

Name: lcd_spi_tx

Overview:
- Downstream consumer of the command/pixel byte FIFO in lcd_basic.
- Pops 9-bit words (DC flag plus byte) over a ready/valid port and serialises each byte MSB-first onto a 4-wire SPI LCD bus (SCLK, MOSI, CS_n, DC), SPI mode 0.
- Keeps CS_n asserted across back-to-back words; releases it after a programmable idle gap.

Parameters:
- CLK_DIV, 2: system clocks per SCLK half-period; legal range 1..255.
- CS_IDLE, 4: clocks spent in TAIL with no new word before CS_n deasserts; legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low; asserted when 0.
- in_ready  out  1  block can accept a word this cycle.
- in_valid  in  1  upstream word present.
- in_data  in  9  [8] = DC (0 command, 1 data); [7:0] = byte.
- lcd_sclk  out  1  SPI clock; idles low.
- lcd_mosi  out  1  serial data, MSB first.
- lcd_cs_n  out  1  chip select, active-low.
- lcd_dc  out  1  data/command select, registered per word.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst).
- All outputs are registered.
- Reset values: in_ready=0, lcd_sclk=0, lcd_mosi=0, lcd_cs_n=1, lcd_dc=0; state=IDLE; all counters 0.
- in_ready is 1 on the first clk edge after rst releases.
- Handshake: a transfer occurs on a clk edge where in_ready & in_valid.
  - in_valid with in_ready=0 is ignored; upstream holds data.
  - in_ready=1 only in IDLE and TAIL.
  - in_ready drops the cycle after acceptance.
- States:
  - IDLE: cs_n=1, sclk=0.
    - Accept → SETUP; same edge: cs_n←0, dc←in_data[8], shift reg←in_data[7:0], mosi←in_data[7].
  - SETUP: sclk=0 for CLK_DIV cycles → SHIFT.
  - SHIFT: sclk high CLK_DIV cycles, then low CLK_DIV cycles. On each falling edge mosi←next bit.
    - After the 8th high phase, go to TAIL (sclk←0) instead of a low phase.
    - Bit counter 0..7.
  - TAIL: sclk=0, cs_n=0, in_ready=1, idle counter increments.
    - Accept → SETUP with the same load actions as IDLE (cs_n stays 0).
    - Counter reaches CS_IDLE with no accept → IDLE, cs_n←1.
    - Accept on the same cycle the counter expires: accept wins; cs_n stays 0.
- Timing:
  - One byte occupies exactly 16*CLK_DIV clocks from SETUP entry to TAIL entry.
  - Back-to-back period is 16*CLK_DIV+1 clocks.
  - Rising edges are centred on stable MOSI.
- lcd_dc changes only on acceptance and is stable for the whole byte.
- mosi holds its last bit in TAIL and IDLE.
- Reset mid-byte: immediate abort, outputs forced to reset values; the partial byte is lost and not re-requested.
- CLK_DIV=1: sclk toggles every clock; behaviour otherwise identical.
- Counter widths: 8 bits for the divide and idle counters; 3 bits for the bit counter.

Optional Feature:
- LCD_SPI_TX_CS_TOGGLE_EN defined:
  - Every TAIL entry drives cs_n←1 for the first CLK_DIV cycles of TAIL, then cs_n←0 if a word is pending or accepted.
  - in_ready is held 0 during that CLK_DIV window.
  - Back-to-back period becomes 17*CLK_DIV+1.
  - CS_IDLE expiry still returns to IDLE with cs_n=1.
- Undefined: CS_n is held low across consecutive words as described in Behaviour.

Test Plan:
- Reset: hold rst=0 for 5 clocks with in_valid=1 → in_ready=0, cs_n=1, sclk=0, no transfer; rst→1 → in_ready=1 next edge.
- Single word, CLK_DIV=2: in_data=0x0A5 →
  - 8 rising sclk edges sample MOSI 1,0,1,0,0,1,0,1.
  - dc=0, cs_n low 32 clocks before TAIL.
  - cs_n returns high CS_IDLE=4 clocks later.
- Back-to-back: 0x12C then 0x1FF held valid →
  - second accept in the first TAIL cycle; 33-clock spacing between first rising edges.
  - cs_n never rises between bytes; dc=1 for both.
- Stall: in_valid drops during a byte, reasserts 2 clocks into TAIL → cs_n stays low, second byte sent. Repeat reasserting at TAIL+6 → cs_n high for ≥1 clock first.
- Mid-byte reset: rst=0 after the 3rd rising edge of 0x0F0 → outputs at reset values within the same cycle (asynchronous); next word after release starts from bit 7.
- LCD_SPI_TX_CS_TOGGLE_EN with CLK_DIV=3: back-to-back 0x001, 0x002 → cs_n high exactly 3 clocks between bytes; period 52 clocks.

Source files
------------

// File: rtl/lcd_spi_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_spi_tx : 9-bit {DC,byte} word to 4-wire SPI LCD serialiser, mode 0.  |
// | Optional: LCD_SPI_TX_CS_TOGGLE_EN pulses CS_n high between words.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lcd_spi_tx #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_IDLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [8:0] in_data,
  output logic       lcd_sclk,
  output logic       lcd_mosi,
  output logic       lcd_cs_n,
  output logic       lcd_dc
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TAIL  = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] IDLE_LAST = 8'(CS_IDLE - 1);

  state_t      state_q;
  logic [7:0]  div_cnt_q;
  logic [7:0]  idle_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        ready_q;
  logic        sclk_q;
  logic        mosi_q;
  logic        cs_n_q;
  logic        dc_q;
  logic        accept;

  // ready_q is only ever set in IDLE or TAIL, so an accept implies one of those states
  assign accept = ready_q & in_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      dc_q       <= 1'b0;
      shift_q    <= 8'd0;
      div_cnt_q  <= 8'd0;
      idle_cnt_q <= 8'd0;
      bit_cnt_q  <= 3'd0;
    end else if (accept) begin
      state_q    <= ST_SETUP;
      ready_q    <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b0;
      dc_q       <= in_data[8];
      shift_q    <= in_data[7:0];
      mosi_q     <= in_data[7];
      div_cnt_q  <= 8'd0;
      idle_cnt_q <= 8'd0;
      bit_cnt_q  <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b0;
        end
        ST_SETUP: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= 8'd0;
            sclk_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        ST_SHIFT: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= 8'd0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else if (bit_cnt_q == 3'd7) begin
              // last high phase ends straight into TAIL, no trailing low phase
              sclk_q     <= 1'b0;
              state_q    <= ST_TAIL;
              idle_cnt_q <= 8'd0;
`ifdef LCD_SPI_TX_CS_TOGGLE_EN
              ready_q    <= 1'b0;
              cs_n_q     <= 1'b1;
`else
              ready_q    <= 1'b1;
`endif
            end else begin
              sclk_q    <= 1'b0;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shift_q   <= {shift_q[6:0], 1'b0};
              mosi_q    <= shift_q[6];
            end
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        ST_TAIL: begin
          if (idle_cnt_q == IDLE_LAST) begin
            state_q <= ST_IDLE;
            cs_n_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            idle_cnt_q <= idle_cnt_q + 8'd1;
`ifdef LCD_SPI_TX_CS_TOGGLE_EN
            if (!ready_q) begin
              if (div_cnt_q == DIV_LAST) begin
                ready_q <= 1'b1;
                cs_n_q  <= ~in_valid;
              end else begin
                div_cnt_q <= div_cnt_q + 8'd1;
              end
            end
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready = ready_q;
  assign lcd_sclk = sclk_q;
  assign lcd_mosi = mosi_q;
  assign lcd_cs_n = cs_n_q;
  assign lcd_dc   = dc_q;

endmodule
`default_nettype wire
